// File: rtl/cpu_bus_pkg.sv
// Shared constants for the bus select encoder.
// Arbitration modes and the no-select code helper.
package cpu_bus_pkg;

  localparam int MODE_STRICT = 0;
  localparam int MODE_PRIO   = 1;
  localparam int MODE_RR     = 2;

  // All-ones code of width w, never a legal source index.
  function automatic int nosel_of(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/bus_select_encoder_if.sv
// Request/result handshake bundle of the bus select encoder.
// master drives requests, slave is the encoder.
interface bus_select_encoder_if #(
  parameter int N_SRC = 24,
  parameter int IDX_W = $clog2(N_SRC + 1),
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [N_SRC-1:0] req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] sel;
  logic             none;
  logic             multi;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, sel,
    input  none, multi, err_cnt
  );

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, sel,
    output none, multi, err_cnt
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Circular first-set-bit search starting at a given index.
// Purely combinational; wraps modulo N.
module rr_priority_pick #(
  parameter int N  = 24,
  parameter int IW = 5
) (
  input  logic [N-1:0]  vec,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0] pos;

  // Walk offsets high to low so the smallest offset wins last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N))
        pos = pos - (IW+1)'(N);
      if (vec[pos[IW-1:0]]) begin
        idx   = pos[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_select_encoder.sv
// Encodes a source request vector into a registered select index
// with one-hot, fixed-priority or round-robin arbitration.
module bus_select_encoder
  import cpu_bus_pkg::*;
#(
  parameter int N_SRC = 24,
  parameter int IDX_W = $clog2(N_SRC + 1),
  parameter int MODE  = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic clr,
  bus_select_encoder_if.slave bus
);

  localparam logic [IDX_W-1:0] NOSEL = IDX_W'(nosel_of(IDX_W));
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_SRC - 1);

  logic             valid_q;
  logic [IDX_W-1:0] sel_q;
  logic             none_q;
  logic             multi_q;
  logic [CNT_W-1:0] err_q;
  logic [IDX_W-1:0] rr_q;

  logic             ready;
  logic             accept;
  logic             zero;
  logic             many;
  logic             found;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] nxt_sel;
  logic             nxt_none;
  logic             nxt_multi;

  assign ready  = !valid_q || bus.out_ready;
  assign accept = bus.in_valid && ready;

  assign zero = (bus.req == '0);
  assign many = |(bus.req & (bus.req - N_SRC'(1)));

  assign rr_next = (rr_q == LAST) ? '0 : rr_q + IDX_W'(1);
  assign start   = (MODE == MODE_RR) ? rr_next : '0;

  rr_priority_pick #(
    .N  (N_SRC),
    .IW (IDX_W)
  ) u_pick (
    .vec   (bus.req),
    .start (start),
    .idx   (pick),
    .found (found)
  );

  // Strict mode rejects multi-hot; other modes grant and flag it.
  always_comb begin
    nxt_sel   = NOSEL;
    nxt_none  = 1'b1;
    nxt_multi = 1'b0;
    unique case (1'b1)
      zero: ;
      (MODE == MODE_STRICT) && many:
        nxt_multi = 1'b1;
      default: begin
        nxt_sel   = pick;
        nxt_none  = 1'b0;
        nxt_multi = many;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q <= 1'b0;
      sel_q   <= NOSEL;
      none_q  <= 1'b1;
      multi_q <= 1'b0;
      err_q   <= '0;
      rr_q    <= LAST;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        sel_q   <= nxt_sel;
        none_q  <= nxt_none;
        multi_q <= nxt_multi;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept && nxt_multi && err_q != '1)
        err_q <= err_q + CNT_W'(1);
      if (MODE == MODE_RR && accept && found)
        rr_q <= pick;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.sel       = sel_q;
  assign bus.none      = none_q;
  assign bus.multi     = multi_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_bus_select_encoder.sv
// Bench: four encoders (strict, priority, round-robin, 2-bit counter)
// driven in lockstep and compared to a bit-counting reference model.
module tb_bus_select_encoder;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic        iv   = 1'b0;
  logic [23:0] rq   = '0;
  logic        ordy = 1'b0;

  bus_select_encoder_if #(.N_SRC(24), .IDX_W(5), .CNT_W(8)) i0 ();
  bus_select_encoder_if #(.N_SRC(24), .IDX_W(5), .CNT_W(8)) i1 ();
  bus_select_encoder_if #(.N_SRC(24), .IDX_W(5), .CNT_W(8)) i2 ();
  bus_select_encoder_if #(.N_SRC(24), .IDX_W(5), .CNT_W(2)) i3 ();

  bus_select_encoder #(.N_SRC(24), .IDX_W(5), .MODE(0), .CNT_W(8))
    u0 (.clk(clk), .clr(clr), .bus(i0));
  bus_select_encoder #(.N_SRC(24), .IDX_W(5), .MODE(1), .CNT_W(8))
    u1 (.clk(clk), .clr(clr), .bus(i1));
  bus_select_encoder #(.N_SRC(24), .IDX_W(5), .MODE(2), .CNT_W(8))
    u2 (.clk(clk), .clr(clr), .bus(i2));
  bus_select_encoder #(.N_SRC(24), .IDX_W(5), .MODE(1), .CNT_W(2))
    u3 (.clk(clk), .clr(clr), .bus(i3));

  assign i0.in_valid = iv;
  assign i0.req = rq;
  assign i0.out_ready = ordy;
  assign i1.in_valid = iv;
  assign i1.req = rq;
  assign i1.out_ready = ordy;
  assign i2.in_valid = iv;
  assign i2.req = rq;
  assign i2.out_ready = ordy;
  assign i3.in_valid = iv;
  assign i3.req = rq;
  assign i3.out_ready = ordy;

  logic [3:0] a_rdy, a_ov, a_none, a_multi;
  logic [4:0] a_sel [4];
  logic [7:0] a_err [4];

  assign a_rdy   = {i3.in_ready, i2.in_ready, i1.in_ready, i0.in_ready};
  assign a_ov    = {i3.out_valid, i2.out_valid, i1.out_valid, i0.out_valid};
  assign a_none  = {i3.none, i2.none, i1.none, i0.none};
  assign a_multi = {i3.multi, i2.multi, i1.multi, i0.multi};
  assign a_sel[0] = i0.sel;
  assign a_sel[1] = i1.sel;
  assign a_sel[2] = i2.sel;
  assign a_sel[3] = i3.sel;
  assign a_err[0] = i0.err_cnt;
  assign a_err[1] = i1.err_cnt;
  assign a_err[2] = i2.err_cnt;
  assign a_err[3] = {6'b0, i3.err_cnt};

  int m_mode [4] = '{0, 1, 2, 1};
  int m_max  [4] = '{255, 255, 255, 3};
  bit mv;
  int msel [4], mnone [4], mmulti [4], merr [4], mrr [4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int d,
                     input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s dut%0d got %0h exp %0h", name, d, got, exp);
    end
  endtask

  function automatic void ref_enc(input int mode, input logic [23:0] r,
                                  input int rr, output int s,
                                  output int nn, output int mu);
    int cnt = 0;
    int low = -1;
    for (int i = 0; i < 24; i++)
      if (r[i]) begin
        cnt++;
        if (low < 0) low = i;
      end
    s  = 31;
    nn = 1;
    mu = (cnt > 1) ? 1 : 0;
    if (mode == 0) begin
      if (cnt == 1) begin s = low; nn = 0; end
    end else if (mode == 1) begin
      if (cnt > 0) begin s = low; nn = 0; end
    end else begin
      for (int k = 1; k <= 24; k++)
        if (nn == 1 && r[(rr + k) % 24]) begin
          s  = (rr + k) % 24;
          nn = 0;
        end
    end
  endfunction

  task automatic model_reset();
    mv = 1'b0;
    for (int d = 0; d < 4; d++) begin
      msel[d] = 31; mnone[d] = 1; mmulti[d] = 0;
      merr[d] = 0;  mrr[d] = 23;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 4; d++) begin
      chk("out_valid", d, 32'(a_ov[d]), int'(mv));
      chk("sel", d, 32'(a_sel[d]), msel[d]);
      chk("none", d, 32'(a_none[d]), mnone[d]);
      chk("multi", d, 32'(a_multi[d]), mmulti[d]);
      chk("err_cnt", d, 32'(a_err[d]), merr[d]);
    end
  endtask

  task automatic cycle(input bit v, input logic [23:0] r, input bit o);
    bit acc;
    int s, nn, mu;
    iv = v; rq = r; ordy = o;
    #1;
    acc = v && (!mv || o);
    for (int d = 0; d < 4; d++)
      chk("in_ready", d, 32'(a_rdy[d]), int'(!mv || o));
    @(posedge clk);
    #1;
    if (acc) begin
      for (int d = 0; d < 4; d++) begin
        ref_enc(m_mode[d], r, mrr[d], s, nn, mu);
        msel[d] = s; mnone[d] = nn; mmulti[d] = mu;
        if (mu == 1 && merr[d] < m_max[d]) merr[d]++;
        if (m_mode[d] == 2 && r != 0) mrr[d] = s;
      end
      mv = 1'b1;
    end else if (o) begin
      mv = 1'b0;
    end
    check_all();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #2;
    model_reset();
    check_all();
    clr = 1'b0;
    #2;
  endtask

  typedef struct {
    logic [23:0] r;
    int          s;
    int          nn;
    int          mu;
  } vec_t;

  vec_t tbl [6];
  int   exp_rr [4] = '{0, 2, 23, 0};

  initial begin
    tbl[0] = '{24'h000010, 4, 0, 0};
    tbl[1] = '{24'h000000, 31, 1, 0};
    tbl[2] = '{24'h000003, 0, 0, 1};
    tbl[3] = '{24'h800000, 23, 0, 0};
    tbl[4] = '{24'hFFFFFF, 0, 0, 1};
    tbl[5] = '{24'h0A0100, 8, 0, 1};

    @(posedge clk);
    #1;
    pulse_clr();

    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[i].r, 1'b1);
      chk("tbl_sel", 1, 32'(a_sel[1]), tbl[i].s);
      chk("tbl_none", 1, 32'(a_none[1]), tbl[i].nn);
      chk("tbl_multi", 1, 32'(a_multi[1]), tbl[i].mu);
      chk("tbl_valid", 1, 32'(a_ov[1]), 1);
    end

    pulse_clr();
    cycle(1'b1, 24'h000003, 1'b1);
    chk("strict_sel", 0, 32'(a_sel[0]), 31);
    chk("strict_multi", 0, 32'(a_multi[0]), 1);
    chk("strict_none", 0, 32'(a_none[0]), 1);
    chk("strict_err", 0, 32'(a_err[0]), 1);
    cycle(1'b1, 24'h000000, 1'b1);
    chk("strict_zero_sel", 0, 32'(a_sel[0]), 31);
    chk("strict_zero_none", 0, 32'(a_none[0]), 1);
    chk("strict_zero_err", 0, 32'(a_err[0]), 1);

    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 24'h800005, 1'b1);
      chk("rr_sel", 2, 32'(a_sel[2]), exp_rr[i]);
    end

    cycle(1'b1, 24'h000010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 24'h000100, 1'b0);
      chk("stall_sel", 1, 32'(a_sel[1]), 4);
      chk("stall_rdy", 1, 32'(a_rdy[1]), 0);
    end
    cycle(1'b1, 24'h000100, 1'b1);
    chk("pop_load_sel", 1, 32'(a_sel[1]), 8);
    chk("pop_load_valid", 1, 32'(a_ov[1]), 1);

    pulse_clr();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 24'h000003, 1'b1);
    chk("pre_clr_err", 1, 32'(a_err[1]), 5);
    clr = 1'b1;
    #1;
    chk("clr_valid", 1, 32'(a_ov[1]), 0);
    chk("clr_sel", 1, 32'(a_sel[1]), 31);
    chk("clr_err", 1, 32'(a_err[1]), 0);
    #1;
    model_reset();
    check_all();
    clr = 1'b0;
    #2;
    cycle(1'b1, 24'h000040, 1'b1);
    chk("post_clr_sel", 1, 32'(a_sel[1]), 6);

    pulse_clr();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 24'h0000F0, 1'b1);
    chk("sat_err", 3, 32'(a_err[3]), 3);

    for (int n = 0; n < 400; n++) begin
      logic [23:0] r;
      bit v, o;
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: r = '0;
        1: r = 24'(1) << $urandom_range(0, 23);
        2: r = 24'($urandom) & 24'($urandom) & 24'($urandom);
        default: r = 24'($urandom);
      endcase
      if ($urandom_range(0, 49) == 0)
        pulse_clr();
      cycle(v, r, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_select_encoder.md
BUS_SELECT_ENCODER -- requirements
Module: bus_select_encoder

Interface
REQ-001 Parameter N_SRC, default 24, number of bus sources (2..63).
REQ-002 Parameter IDX_W, default $clog2(N_SRC+1) (=5), width of the encoded select.
REQ-003 Parameter MODE, default 1, arbitration mode: 0 strict one-hot, 1 fixed priority, 2 round-robin.
REQ-004 Parameter CNT_W, default 8, width of the error counter.
REQ-005 Port clk  input  1  the single clock; all state changes on the rising edge.
REQ-006 Port clr  input  1  reset, asynchronous, active-high.
REQ-007 Port in_valid  input  1  req vector is presented.
REQ-008 Port in_ready  output  1  block accepts req this cycle.
REQ-009 Port req  input  N_SRC  source request / drive-enable vector; bit i = source i.
REQ-010 Port out_valid  output  1  registered result is available.
REQ-011 Port out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port sel  output  IDX_W  encoded source index; all-ones = no select (NOSEL).
REQ-013 Port none  output  1  accepted req was all-zero, or was rejected in MODE 0.
REQ-014 Port multi  output  1  accepted req had more than one bit set.
REQ-015 Port err_cnt  output  CNT_W  saturating count of accepted multi-hot vectors.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready); it is combinational from out_valid and out_ready only.
REQ-017 Accept = in_valid && in_ready; on accept, sel/none/multi SHALL update at the next edge with out_valid=1 (latency 1 cycle).
REQ-018 Without accept and with out_valid && out_ready, out_valid SHALL clear; sel/none/multi SHALL hold their last values.
REQ-019 While out_valid && !out_ready, sel/none/multi/out_valid SHALL remain stable.
REQ-020 Simultaneous pop and accept SHALL load the new result with out_valid remaining 1 (full throughput).
REQ-021 MODE 0: exactly one bit set -> sel = its index; zero bits -> sel=NOSEL, none=1; >1 bit -> sel=NOSEL, multi=1, none=1.
REQ-022 MODE 1: sel = lowest set index; multi=1 if >1 bit set; zero bits -> sel=NOSEL, none=1.
REQ-023 MODE 2: search starts at rr_ptr+1 and wraps modulo N_SRC; first set bit wins; multi as MODE 1.
REQ-024 MODE 2: rr_ptr SHALL update to the granted index on accept with non-zero req; otherwise rr_ptr holds.
REQ-025 err_cnt SHALL increment on each accept with multi condition true, saturating at all-ones.
REQ-026 NOSEL SHALL never equal a valid index (guaranteed by IDX_W rule, REQ-002).

Reset
REQ-027 clr asserted SHALL immediately force out_valid=0, sel=NOSEL, none=1, multi=0, err_cnt=0, rr_ptr=N_SRC-1.
REQ-028 clr mid-transfer SHALL discard the pending result; the first accept after release is processed normally.

Structure
REQ-029 Package cpu_bus_pkg SHALL hold MODE constants (MODE_STRICT, MODE_PRIO, MODE_RR) and the NOSEL-generating function.
REQ-030 Sub-module rr_priority_pick (combinational: vector, start index -> index, found) SHALL serve MODE 1 (start 0) and MODE 2.

Verification
REQ-031 MODE 1, req=24'h000010 accepted, out_ready=1 -> next cycle sel=4, none=0, multi=0, out_valid=1.
REQ-032 MODE 0, req=24'h000003 -> sel=5'h1F, multi=1, none=1, err_cnt 0->1; req=0 -> sel=5'h1F, none=1, err_cnt unchanged.
REQ-033 MODE 2, req=24'h800005 accepted three times back-to-back -> sel 0, 2, 23; fourth -> 0 (wrap).
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, sel stable; out_ready=1 -> pop and new accept same edge.
REQ-035 clr pulsed while out_valid=1 and err_cnt=5 -> out_valid=0, sel=5'h1F, err_cnt=0 before next clk edge.
REQ-036 MODE 1, CNT_W=2, four multi-hot accepts -> err_cnt saturates at 3.
